// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - instruction sequencing FSM for the 4-bit/8-bit teaching CPU
module cpu_control_unit #(
    parameter logic [1:0] START_SEL    = 2'b10,
    parameter int         NOP_ON_UNDEF = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic [3:0] IRCU,
    input  logic       Zflag,
    output logic       IRload,
    output logic       PCload,
    output logic [1:0] JSM,
    output logic       ANSload,
    output logic       Aload,
    output logic       Bload,
    output logic       select_mode,
    output logic [2:0] ALUsel,
    output logic       OUTload,
    output logic       Halted,
    output logic [2:0] State
);
    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_LOADIR = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge Clk) begin
        if (!Reset) state_q <= S_START;
        else        state_q <= state_d;
    end

    assign State = state_q;

    always_comb begin
        state_d     = state_q;
        IRload      = 1'b0;
        PCload      = 1'b0;
        JSM         = 2'b00;
        ANSload     = 1'b0;
        Aload       = 1'b0;
        Bload       = 1'b0;
        select_mode = 1'b0;
        ALUsel      = 3'b000;
        OUTload     = 1'b0;
        Halted      = 1'b0;
        case (state_q)
            S_START: begin
                PCload  = 1'b1;
                JSM     = START_SEL;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (Run) state_d = S_LOADIR;
            end
            S_LOADIR: begin
                IRload  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Jumps resolve here and skip EXEC; everything else advances PC and runs EXEC.
                case (IRCU)
                    4'b1000: begin
                        PCload  = 1'b1;
                        JSM     = 2'b01;
                        state_d = S_FETCH;
                    end
                    4'b1001: begin
                        PCload  = 1'b1;
                        JSM     = Zflag ? 2'b01 : 2'b00;
                        state_d = S_FETCH;
                    end
                    4'b1010: begin
                        PCload  = 1'b1;
                        JSM     = Zflag ? 2'b00 : 2'b01;
                        state_d = S_FETCH;
                    end
                    4'b1111: state_d = S_HALT;
                    4'b1100, 4'b1101, 4'b1110: begin
                        if (NOP_ON_UNDEF != 0) begin
                            PCload  = 1'b1;
                            state_d = S_EXEC;
                        end else begin
                            state_d = S_HALT;
                        end
                    end
                    default: begin
                        PCload  = 1'b1;
                        state_d = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (IRCU)
                    4'b0001: begin
                        Aload       = 1'b1;
                        select_mode = 1'b1;
                    end
                    4'b0010: begin
                        Bload       = 1'b1;
                        select_mode = 1'b1;
                    end
                    4'b0011: ANSload = 1'b1;
                    4'b0100: begin
                        ANSload = 1'b1;
                        ALUsel  = 3'b001;
                    end
                    4'b0101: begin
                        ANSload = 1'b1;
                        ALUsel  = 3'b010;
                    end
                    4'b0110: begin
                        ANSload = 1'b1;
                        ALUsel  = 3'b011;
                    end
                    4'b0111: begin
                        ANSload = 1'b1;
                        ALUsel  = 3'b100;
                    end
                    4'b1011: OUTload = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: Halted = 1'b1;
            default: state_d = S_START;
        endcase
        // Reset masks every output immediately, even before the state register clears.
        if (!Reset) begin
            IRload      = 1'b0;
            PCload      = 1'b0;
            JSM         = 2'b00;
            ANSload     = 1'b0;
            Aload       = 1'b0;
            Bload       = 1'b0;
            select_mode = 1'b0;
            ALUsel      = 3'b000;
            OUTload     = 1'b0;
            Halted      = 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - randomized instruction-level bench for cpu_control_unit
module tb_cpu_control_unit;
    logic       Clk = 1'b0;
    logic       Reset, Run, Zflag;
    logic [3:0] IRCU;
    logic       IRload, PCload, ANSload, Aload, Bload, select_mode, OUTload, Halted;
    logic [1:0] JSM;
    logic [2:0] ALUsel, State;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_control_unit dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .IRCU(IRCU), .Zflag(Zflag),
        .IRload(IRload), .PCload(PCload), .JSM(JSM), .ANSload(ANSload),
        .Aload(Aload), .Bload(Bload), .select_mode(select_mode), .ALUsel(ALUsel),
        .OUTload(OUTload), .Halted(Halted), .State(State)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] mk(input logic [2:0] st, input logic irl, input logic pcl,
                                       input logic [1:0] jsm, input logic ans, input logic a,
                                       input logic b, input logic sm, input logic [2:0] alu,
                                       input logic outl, input logic h);
        return {irl, pcl, jsm, ans, a, b, sm, alu, outl, h, st};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [15:0] exp);
        @(negedge Clk);
        chk(tag, {IRload, PCload, JSM, ANSload, Aload, Bload, select_mode, ALUsel,
                  OUTload, Halted, State}, exp);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] cur);
        Reset = 1'b0;
        Run   = 1'($urandom);
        cyc("reset_mask", mk(cur, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0));
        Reset = 1'b1;
        cyc("start", mk(3'd0, 0, 1, 2'b10, 0, 0, 0, 0, 3'b000, 0, 0));
    endtask

    // One instruction from FETCH entry; z<0 means random Zflag in DECODE.
    task automatic run_instr(input logic [3:0] op, input int stalls, input int z,
                             input bit rst_in_exec);
        logic zf, is_jump, taken, is_halt, is_ans;
        logic [2:0] alu;
        for (int i = 0; i < stalls; i++) begin
            Run = 1'b0; IRCU = 4'($urandom); Zflag = 1'($urandom);
            cyc("fetch_stall", mk(3'd1, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0));
        end
        Run = 1'b1; IRCU = 4'($urandom); Zflag = 1'($urandom);
        cyc("fetch", mk(3'd1, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0));
        Run = 1'($urandom); IRCU = op; Zflag = 1'($urandom);
        cyc("loadir", mk(3'd2, 1, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0));

        zf      = (z < 0) ? 1'($urandom) : 1'(z);
        Zflag   = zf;
        Run     = 1'($urandom);
        is_jump = (op >= 4'd8 && op <= 4'd10);
        taken   = (op == 4'd8) || (op == 4'd9 && zf) || (op == 4'd10 && !zf);
        is_halt = (op == 4'd15);
        if (is_halt)
            cyc("decode_halt", mk(3'd3, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0));
        else
            cyc("decode", mk(3'd3, 0, 1, (is_jump && taken) ? 2'b01 : 2'b00,
                             0, 0, 0, 0, 3'b000, 0, 0));

        if (is_halt) begin
            int hold = $urandom_range(2, 10);
            if (stalls == 99) hold = 10;
            for (int i = 0; i < hold; i++) begin
                Run = 1'($urandom); Zflag = 1'($urandom); IRCU = 4'($urandom);
                cyc("halt", mk(3'd5, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 1));
            end
            do_reset(3'd5);
        end else if (!is_jump) begin
            Zflag  = 1'($urandom);
            Run    = 1'($urandom);
            is_ans = (op >= 4'd3 && op <= 4'd7);
            alu    = is_ans ? 3'(op - 4'd3) : 3'b000;
            if (rst_in_exec) begin
                Reset = 1'b0;
                cyc("exec_reset", mk(3'd4, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0));
                Reset = 1'b1;
                cyc("start_after_exec", mk(3'd0, 0, 1, 2'b10, 0, 0, 0, 0, 3'b000, 0, 0));
            end else begin
                cyc("exec", mk(3'd4, 0, 0, 2'b00, is_ans, op == 4'd1, op == 4'd2,
                               (op == 4'd1 || op == 4'd2), alu, op == 4'd11, 0));
            end
        end
    endtask

    initial begin
        Reset = 1'b0; Run = 1'b0; IRCU = 4'd0; Zflag = 1'b0;
        @(posedge Clk);
        #1;
        cyc("reset_hold", mk(3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0));
        Reset = 1'b1;
        cyc("start", mk(3'd0, 0, 1, 2'b10, 0, 0, 0, 0, 3'b000, 0, 0));

        run_instr(4'b0011, 0, -1, 1'b0);
        run_instr(4'b1001, 0, 1, 1'b0);
        run_instr(4'b1001, 0, 0, 1'b0);
        run_instr(4'b1010, 0, 0, 1'b0);
        run_instr(4'b0000, 5, -1, 1'b0);
        run_instr(4'b1101, 0, -1, 1'b0);
        run_instr(4'b1101, 0, -1, 1'b1);
        run_instr(4'b1111, 99, -1, 1'b0);
        for (int k = 0; k < 200; k++)
            run_instr(4'($urandom), $urandom_range(0, 2), -1, ($urandom_range(0, 15) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
